ram_refresh_sched: RTL and testbench

Schedules the shared motherboard RAM between CPU accesses and CAS-before-RAS refresh cycles. It takes the refresh timer's RefReq/RefUrg indications and tracks how many refreshes are owed. It grants the RAM to the CPU when no refresh is urgent, and sequences the refresh strobes itself. It sits between the timer/QoS counter block and the RAM strobe multiplexer.

---
 rtl/ram_sched_pkg.sv | 10 +
 rtl/ref_debt_ctr.sv | 49 ++++
 rtl/ram_refresh_sched.sv | 102 ++++++++++
 tb/tb_ram_refresh_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ram_sched_pkg.sv
// ram_sched_pkg: shared state encoding, default refresh timing and debt width
package ram_sched_pkg;
    typedef enum logic [2:0] {IDLE, CPU, CBR_CAS, CBR_RAS, PRECH} state_t;
    localparam int unsigned T_CSR_DEF    = 1;
    localparam int unsigned T_RAS_DEF    = 4;
    localparam int unsigned T_RP_DEF     = 2;
    localparam int unsigned DEBT_MAX_DEF = 3;
    // DEBT_MAX never exceeds 3, so two bits always hold the owed count
    localparam int unsigned DEBT_W       = 2;
endpackage

// File: rtl/ref_debt_ctr.sv
// ref_debt_ctr: counts owed refreshes from RefReq rises, saturates, flags lost ones
//   clk, rst  : clock, synchronous active-high reset
//   ref_req   : timer request level, each rise owes one refresh
//   dec       : final precharge cycle, one owed refresh paid off
//   debt      : owed refresh count
//   overrun   : sticky, a rise arrived while saturated
module ref_debt_ctr
    import ram_sched_pkg::*;
#(
    parameter int unsigned DEBT_MAX = DEBT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_req,
    input  logic              dec,
    output logic [DEBT_W-1:0] debt,
    output logic              overrun
);
    logic              req_q;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              overrun_q, overrun_d;
    logic              rise, full;

    assign rise = ref_req && !req_q;
    assign full = debt_q == DEBT_W'(DEBT_MAX);

    // a simultaneous rise and payoff cancel, so neither path fires
    always_comb begin
        debt_d    = (rise && !dec && !full)           ? debt_q + 1'b1
                  : (dec && !rise && debt_q != '0)    ? debt_q - 1'b1
                  : debt_q;
        overrun_d = overrun_q || (rise && !dec && full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= 1'b0;
            debt_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            req_q     <= ref_req;
            debt_q    <= debt_d;
            overrun_q <= overrun_d;
        end
    end

    assign debt    = debt_q;
    assign overrun = overrun_q;
endmodule

// File: rtl/ram_refresh_sched.sv
// ram_refresh_sched: arbitrates shared RAM between CPU cycles and CBR refresh
//   CLK, RST        : clock, synchronous active-high reset
//   RefReq, RefUrg  : timer refresh request / urgency levels
//   CpuReq, CpuDone : CPU cycle pending level / end-of-cycle pulse
//   CpuGnt          : CPU owns the RAM
//   RefCAS, RefRAS  : refresh strobe requests
//   RefBusy         : refresh sequence in progress
//   RefDebt         : owed refreshes
//   RefOverrun      : sticky, an owed refresh was lost to saturation
module ram_refresh_sched
    import ram_sched_pkg::*;
#(
    parameter int unsigned T_CSR    = T_CSR_DEF,
    parameter int unsigned T_RAS    = T_RAS_DEF,
    parameter int unsigned T_RP     = T_RP_DEF,
    parameter int unsigned DEBT_MAX = DEBT_MAX_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RefReq,
    input  logic              RefUrg,
    input  logic              CpuReq,
    input  logic              CpuDone,
    output logic              CpuGnt,
    output logic              RefCAS,
    output logic              RefRAS,
    output logic              RefBusy,
    output logic [DEBT_W-1:0] RefDebt,
    output logic              RefOverrun
);
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       cpu_gnt_q, cpu_gnt_d;
    logic       ref_cas_q, ref_cas_d;
    logic       ref_ras_q, ref_ras_d;
    logic       ref_busy_q, ref_busy_d;
    logic       last, ref_done, owed;

    assign last     = cnt_q == 3'd0;
    assign ref_done = state_q == PRECH && last;
    assign owed     = RefDebt != '0;

    ref_debt_ctr #(.DEBT_MAX(DEBT_MAX)) u_debt (
        .clk     (CLK),
        .rst     (RST),
        .ref_req (RefReq),
        .dec     (ref_done),
        .debt    (RefDebt),
        .overrun (RefOverrun)
    );

    // cnt holds remaining cycles minus one of the current refresh phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 3'd1;
        case (state_q)
            IDLE: begin
                state_d = (owed && (RefUrg || !CpuReq)) ? CBR_CAS : CpuReq ? CPU : IDLE;
                cnt_d   = 3'(T_CSR - 1);
            end
            CPU:     state_d = CpuDone ? IDLE : CPU;
            CBR_CAS: if (last) begin
                state_d = CBR_RAS;
                cnt_d   = 3'(T_RAS - 1);
            end
            CBR_RAS: if (last) begin
                state_d = PRECH;
                cnt_d   = 3'(T_RP - 1);
            end
            PRECH:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they register alongside it
        cpu_gnt_d  = state_d == CPU;
        ref_ras_d  = state_d == CBR_RAS;
        ref_cas_d  = state_d == CBR_CAS || ref_ras_d;
        ref_busy_d = ref_cas_d || state_d == PRECH;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            cpu_gnt_q  <= 1'b0;
            ref_cas_q  <= 1'b0;
            ref_ras_q  <= 1'b0;
            ref_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_gnt_q  <= cpu_gnt_d;
            ref_cas_q  <= ref_cas_d;
            ref_ras_q  <= ref_ras_d;
            ref_busy_q <= ref_busy_d;
        end
    end

    assign CpuGnt  = cpu_gnt_q;
    assign RefCAS  = ref_cas_q;
    assign RefRAS  = ref_ras_q;
    assign RefBusy = ref_busy_q;
endmodule

// File: tb/tb_ram_refresh_sched.sv
// tb_ram_refresh_sched: directed checks of arbitration, refresh timing, debt and reset
module tb_ram_refresh_sched;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RefReq = 1'b0, RefUrg = 1'b0, CpuReq = 1'b0, CpuDone = 1'b0;
    logic       CpuGnt, RefCAS, RefRAS, RefBusy, RefOverrun;
    logic [1:0] RefDebt;
    int         tests = 0;
    int         fails = 0;

    ram_refresh_sched dut (
        .CLK(CLK), .RST(RST), .RefReq(RefReq), .RefUrg(RefUrg),
        .CpuReq(CpuReq), .CpuDone(CpuDone), .CpuGnt(CpuGnt),
        .RefCAS(RefCAS), .RefRAS(RefRAS), .RefBusy(RefBusy),
        .RefDebt(RefDebt), .RefOverrun(RefOverrun)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // exp = {gnt, cas, ras, busy, debt[1:0], overrun}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {CpuGnt, RefCAS, RefRAS, RefBusy, RefDebt, RefOverrun};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got gnt/cas/ras/busy/debt/ovr=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("reset", 7'b0000000);
        RST = 1'b0;
        step(2);
        chk("idle", 7'b0000000);

        // background refresh
        RefReq = 1'b1;
        step(); chk("bg debt", 7'b0000010);
        step(); chk("bg cas", 7'b0101010);
        step(); chk("bg ras first", 7'b0111010);
        step(3); chk("bg ras last", 7'b0111010);
        step(); chk("bg prech1", 7'b0001010);
        step(); chk("bg prech2", 7'b0001010);
        step(); chk("bg done", 7'b0000000);
        RefReq = 1'b0;
        step();

        // cpu first with non-urgent debt
        RefReq = 1'b1; CpuReq = 1'b1;
        step(); chk("cpu gnt", 7'b1000010);
        CpuReq = 1'b0;
        step(); chk("cpu hold", 7'b1000010);
        CpuDone = 1'b1;
        step(); chk("cpu done idle", 7'b0000010);
        CpuDone = 1'b0;
        step(); chk("cpu then cas", 7'b0101010);
        step(7); chk("cpu ref done", 7'b0000000);
        RefReq = 1'b0;
        step();

        // urgent refresh wins over pending cpu
        RefReq = 1'b1; RefUrg = 1'b1;
        step(); chk("urg debt", 7'b0000010);
        CpuReq = 1'b1;
        step(); chk("urg cas", 7'b0101010);
        step(3); chk("urg ras", 7'b0111010);
        step(3); chk("urg prech", 7'b0001010);
        step(); chk("urg idle", 7'b0000000);
        RefUrg = 1'b0;
        step(); chk("urg then gnt", 7'b1000000);
        CpuReq = 1'b0; CpuDone = 1'b1;
        step(); chk("urg cpu done", 7'b0000000);
        CpuDone = 1'b0;

        // no preemption of a granted cpu cycle
        RefReq = 1'b0; CpuReq = 1'b1;
        step(); chk("np gnt", 7'b1000000);
        CpuReq = 1'b0; RefReq = 1'b1; RefUrg = 1'b1;
        step(); chk("np debt in cpu", 7'b1000010);
        step(); chk("np still cpu", 7'b1000010);
        CpuDone = 1'b1;
        step(); chk("np idle", 7'b0000010);
        CpuDone = 1'b0;
        step(); chk("np cas", 7'b0101010);
        RefUrg = 1'b0;
        step(7); chk("np done", 7'b0000000);

        // saturation while cpu holds the ram
        RefReq = 1'b0; CpuReq = 1'b1;
        step(); chk("sat gnt", 7'b1000000);
        CpuReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RefReq = 1'b1; step();
            RefReq = 1'b0; step();
            if (i == 2) chk("sat debt3", 7'b1000110);
        end
        chk("sat overrun", 7'b1000111);
        CpuDone = 1'b1;
        step(); chk("sat idle", 7'b0000111);
        CpuDone = 1'b0;
        step(); chk("sat cas1", 7'b0101111);
        step(7); chk("sat gap1", 7'b0000101);
        step(); chk("sat cas2", 7'b0101101);
        step(7); chk("sat gap2", 7'b0000011);
        step(); chk("sat cas3", 7'b0101011);
        step(7); chk("sat end", 7'b0000001);
        step(2); chk("sat stays", 7'b0000001);

        // reset mid-refresh
        RefReq = 1'b1;
        step(); chk("rst debt", 7'b0000011);
        step(2); chk("rst in ras", 7'b0111011);
        RST = 1'b1; RefReq = 1'b0;
        step(); chk("rst abort", 7'b0000000);
        RST = 1'b0;
        CpuDone = 1'b1;
        step(); chk("cpudone ignored", 7'b0000000);
        CpuDone = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
